hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of saturating stall-cycle counter.
REQ-002 CLK  in  1  clock; all state updates on rising edge.
REQ-003 RSTN  in  1  reset, asynchronous, active-low.
REQ-004 id_ra  in  5  ID-stage source register A number.
REQ-005 id_rb  in  5  ID-stage source register B number.
REQ-006 id_use_ra  in  1  ID instruction reads id_ra.
REQ-007 id_use_rb  in  1  ID instruction reads id_rb.
REQ-008 ex_ra  in  5  EX-stage source A number (from ID/EX register).
REQ-009 ex_rb  in  5  EX-stage source B number (from ID/EX register).
REQ-010 ex_rd  in  5  EX-stage destination.
REQ-011 ex_reg_write  in  1  EX instruction writes ex_rd.
REQ-012 ex_mem_read  in  1  EX instruction is a load.
REQ-013 mem_rd  in  5  MEM-stage destination.
REQ-014 mem_reg_write  in  1  MEM instruction writes mem_rd.
REQ-015 wb_rd  in  5  WB-stage destination.
REQ-016 wb_reg_write  in  1  WB instruction writes wb_rd.
REQ-017 branch_taken  in  1  taken branch/jump resolved in EX this cycle.
REQ-018 Stall  out  1  to ID/EX: load bubble (zeroed WB/MEM/EX control) next edge.
REQ-019 pc_write  out  1  PC update enable.
REQ-020 if_id_write  out  1  IF/ID update enable.
REQ-021 if_id_flush  out  1  IF/ID clear to NOP.
REQ-022 fwd_a  out  2  EX operand A select: 00 regfile, 01 WB, 10 MEM.
REQ-023 fwd_b  out  2  EX operand B select, same encoding.
REQ-024 stall_cycles  out  CNT_W  count of cycles with hazard Stall asserted.

Function
REQ-025 SHALL implement FSM {RUN, HOLD} plus 2-bit bubble counter cnt; outputs Mealy (state + current inputs).
REQ-026 Hazard match: (id_use_ra && id_ra==R) || (id_use_rb && id_rb==R); all 32 registers treated alike, no r0 special case.
REQ-027 RUN, no hazard, no branch: Stall=0, pc_write=1, if_id_write=1, if_id_flush=0.
REQ-028 RUN, hazard needing N bubbles: same cycle Stall=1, pc_write=0, if_id_write=0; N=1 stays RUN; N=2 goes HOLD with cnt=1.
REQ-029 HOLD: Stall=1, pc_write=0, if_id_write=0 regardless of hazard inputs; cnt decrements; cnt reaching 0 returns RUN.
REQ-030 branch_taken=1 in any state has priority: Stall=1, if_id_flush=1, pc_write=1, if_id_write=0; next state RUN, cnt=0.
REQ-031 Forwarding: fwd_x=10 if mem_reg_write && mem_rd==ex_rx; else 01 if wb_reg_write && wb_rd==ex_rx; else 00 (MEM priority over WB).
REQ-032 stall_cycles increments on each cycle with Stall=1 and branch_taken=0; saturates at all-ones, no wrap.
REQ-033 Register file is write-before-read; no hazard against WB stage is ever raised.

Reset
REQ-034 RSTN low: state=RUN, cnt=0, stall_cycles=0 immediately; reset mid-HOLD abandons remaining bubbles.
REQ-035 During reset, outputs follow RUN rules for current inputs.

Configuration
REQ-036 FORWARDING_EN defined: only load-use (ex_mem_read && ex_reg_write && match ex_rd) raises hazard, N=1; fwd_a/fwd_b per REQ-031.
REQ-037 FORWARDING_EN undefined: match ex_rd with ex_reg_write gives N=2; else match mem_rd with mem_reg_write gives N=1; fwd_a/fwd_b tied 00.

Structure
REQ-038 Forward-select encodings and FSM state encoding SHALL live in the shared pipeline package; no sub-module; FSM, counter, and forwarding logic in one module.

Verification
REQ-039 Reset: RSTN=0 during HOLD -> state RUN, stall_cycles=0, pc_write=1 with no hazard inputs.
REQ-040 FORWARDING_EN, ex load rd=5, id_ra=5 use -> exactly 1 cycle Stall=1/pc_write=0; fwd_a=10 next cycle with mem_rd=5.
REQ-041 No FORWARDING_EN, ex_rd=3 write, id_rb=3 use -> Stall=1 for exactly 2 cycles; stall_cycles +2.
REQ-042 branch_taken=1 during HOLD -> same cycle if_id_flush=1, pc_write=1; next cycle RUN, Stall=0.
REQ-043 mem_rd=wb_rd=7, both writing, ex_ra=7 -> fwd_a=10; drop mem_reg_write -> fwd_a=01.
REQ-044 CNT_W=4, 20 hazard stalls -> stall_cycles holds 15.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM states, forward-select codes
// and the register-match helpers.
package hazard_ctrl_pkg;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HOLD = 1'b1
   } hz_state_t;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // True when the ID instruction reads register r through either source port.
   function automatic logic src_match(input logic       use_a,
                                      input logic [4:0] ra,
                                      input logic       use_b,
                                      input logic [4:0] rb,
                                      input logic [4:0] r);
      return (use_a && (ra == r)) || (use_b && (rb == r));
   endfunction

   // MEM result is younger than WB, so it wins when both target the same register.
   function automatic logic [1:0] fwd_sel(input logic       mem_we,
                                          input logic [4:0] mem_rd,
                                          input logic       wb_we,
                                          input logic [4:0] wb_rd,
                                          input logic [4:0] src);
      if (mem_we && (mem_rd == src))
         return FWD_MEM;
      else if (wb_we && (wb_rd == src))
         return FWD_WB;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load/data-hazard bubbles, branch flush, operand forwarding and
// a saturating stall-cycle counter. Define FORWARDING_EN to enable the forwarding datapath.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RSTN,
   input  logic [4:0]       id_ra,
   input  logic [4:0]       id_rb,
   input  logic             id_use_ra,
   input  logic             id_use_rb,
   input  logic [4:0]       ex_ra,
   input  logic [4:0]       ex_rb,
   input  logic [4:0]       ex_rd,
   input  logic             ex_reg_write,
   input  logic             ex_mem_read,
   input  logic [4:0]       mem_rd,
   input  logic             mem_reg_write,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_write,
   input  logic             branch_taken,
   output logic             Stall,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cycles
);

   hz_state_t        r_state;
   hz_state_t        w_state_nx;
   logic [1:0]       r_cnt;
   logic [1:0]       w_cnt_nx;
   logic [CNT_W-1:0] r_sc;

   logic             w_hz_ex;
   logic             w_hz_mem;
   logic             w_need;
   logic             w_need2;
   logic             w_stall;
   logic [1:0]       w_fwd_a;
   logic [1:0]       w_fwd_b;

   assign w_hz_ex  = src_match(id_use_ra, id_ra, id_use_rb, id_rb, ex_rd);
   assign w_hz_mem = src_match(id_use_ra, id_ra, id_use_rb, id_rb, mem_rd);

`ifdef FORWARDING_EN
   // Only a load result is too late to forward; one bubble lets it reach MEM.
   assign w_need  = ex_mem_read && ex_reg_write && w_hz_ex;
   assign w_need2 = 1'b0;
   assign w_fwd_a = fwd_sel(mem_reg_write, mem_rd, wb_reg_write, wb_rd, ex_ra);
   assign w_fwd_b = fwd_sel(mem_reg_write, mem_rd, wb_reg_write, wb_rd, ex_rb);
   logic w_unused;
   assign w_unused = w_hz_mem;
`else
   // Without forwarding, results are visible only once written back (write-before-read).
   assign w_need2 = ex_reg_write && w_hz_ex;
   assign w_need  = w_need2 || (mem_reg_write && w_hz_mem);
   assign w_fwd_a = FWD_RF;
   assign w_fwd_b = FWD_RF;
   logic w_unused;
   assign w_unused = ^{ex_ra, ex_rb, ex_mem_read, wb_rd, wb_reg_write};
`endif

   always_comb begin
      w_stall     = 1'b0;
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      if_id_flush = 1'b0;
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt;
      if (branch_taken) begin
         w_stall     = 1'b1;
         if_id_flush = 1'b1;
         if_id_write = 1'b0;
         w_state_nx  = ST_RUN;
         w_cnt_nx    = 2'd0;
      end else begin
         unique case (r_state)
            ST_RUN: begin
               if (w_need) begin
                  w_stall     = 1'b1;
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  if (w_need2) begin
                     w_state_nx = ST_HOLD;
                     w_cnt_nx   = 2'd1;
                  end
               end
            end
            ST_HOLD: begin
               w_stall     = 1'b1;
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               w_cnt_nx    = (r_cnt == 2'd0) ? 2'd0 : r_cnt - 2'd1;
               if (w_cnt_nx == 2'd0)
                  w_state_nx = ST_RUN;
            end
            default: begin
               w_state_nx = ST_RUN;
               w_cnt_nx   = 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= ST_RUN;
         r_cnt   <= 2'd0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   // Branch-flush cycles are not hazard stalls and are excluded from the count.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN)
         r_sc <= '0;
      else if (w_stall && !branch_taken && (r_sc != {CNT_W{1'b1}}))
         r_sc <= r_sc + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign Stall        = w_stall;
   assign fwd_a        = w_fwd_a;
   assign fwd_b        = w_fwd_b;
   assign stall_cycles = r_sc;

endmodule
